// File: rtl/ccr_request_arbiter.sv
// Round-robin arbiter/sequencer sharing one customer_care_registry among NUM_REQ requesters.
// Optional build macro CCR_ARB_HIT_CHECK_EN enables the search-hit ID comparator.
module ccr_request_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 8,
    parameter int DATA_W   = 128,
    parameter int CMD_HOLD = 1,
    parameter int REG_LAT  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_op,
    input  logic [NUM_REQ*ID_W-1:0]   req_id,
    input  logic [NUM_REQ*DATA_W-1:0] req_phone,
    input  logic [NUM_REQ*DATA_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_phone,
    output logic [DATA_W-1:0]         resp_addr,
    output logic                      resp_hit,
    output logic                      busy,
    output logic [ID_W-1:0]           reg_customer_id,
    output logic [DATA_W-1:0]         reg_phone_number,
    output logic [DATA_W-1:0]         reg_address,
    output logic                      reg_add_customer,
    output logic                      reg_search_customer,
    input  logic [ID_W-1:0]           reg_found_customer_id,
    input  logic [DATA_W-1:0]         reg_found_phone_number,
    input  logic [DATA_W-1:0]         reg_found_address
);

    localparam int LG_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (CMD_HOLD > REG_LAT) ? CMD_HOLD : REG_LAT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic              op;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] phone;
        logic [DATA_W-1:0] addr;
    } req_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [LG_W-1:0]        last_grant, grant_idx;
    logic [NUM_REQ-1:0]     grant;
    logic                   lat_op;
    logic                   accept, capture;
    logic                   hit_nxt;
    req_t [NUM_REQ-1:0]     req_q;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
        assign req_q[k] = '{op:    req_op[k],
                            id:    req_id[k*ID_W +: ID_W],
                            phone: req_phone[k*DATA_W +: DATA_W],
                            addr:  req_addr[k*DATA_W +: DATA_W]};
    end

    // Rotating priority: search begins just after the last winner and wraps.
    always_comb begin
        int  idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = LG_W'(idx);
            end
        end
    end

    // Gated by rst_n so the accept stays low while reset is held.
    assign req_ready = (rst_n && state == IDLE) ? grant : '0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (|grant) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_W'(CMD_HOLD - 1);
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt == '0) begin
                    cnt_nxt   = CNT_W'(REG_LAT - 1);
                    state_nxt = WAIT;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef CCR_ARB_HIT_CHECK_EN
    // Adds always report a hit; searches hit only on a nonzero matching ID.
    assign hit_nxt = lat_op ||
                     ((reg_found_customer_id == reg_customer_id) && (reg_customer_id != '0));
`else
    assign hit_nxt = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            last_grant       <= LG_W'(NUM_REQ - 1);
            lat_op           <= 1'b0;
            reg_customer_id  <= '0;
            reg_phone_number <= '0;
            reg_address      <= '0;
            resp_id          <= '0;
            resp_phone       <= '0;
            resp_addr        <= '0;
            resp_hit         <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                last_grant       <= grant_idx;
                lat_op           <= req_q[grant_idx].op;
                reg_customer_id  <= req_q[grant_idx].id;
                reg_phone_number <= req_q[grant_idx].phone;
                reg_address      <= req_q[grant_idx].addr;
            end
            if (capture) begin
                resp_id    <= reg_found_customer_id;
                resp_phone <= reg_found_phone_number;
                resp_addr  <= reg_found_address;
                resp_hit   <= hit_nxt;
            end
        end
    end

    assign busy                = (state != IDLE);
    assign reg_add_customer    = (state == ISSUE) &&  lat_op;
    assign reg_search_customer = (state == ISSUE) && !lat_op;
    assign resp_valid          = (state == RESP) ? (NUM_REQ'(1) << last_grant) : '0;

endmodule
